core_seq: RTL and testbench
===========================

# core_seq

Multi-cycle sequencer for the RV32 single-cycle datapath. Sits between the core (PC register, register file, decode) and a single shared valid/ready memory port. It fetches each instruction, optionally performs one data access on behalf of the core, then issues a one-cycle commit that enables the PC and register-file write. It also handles halt (ebreak) and bus timeout.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; fixed at 32 for this core.
- `TIMEOUT`, default 255: maximum wait cycles in any request or response state before the error state is entered; must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; low forces reset state immediately.
- `pc`  in  ADDR_W  current PC from the core PC register.
- `ist`  out  32  held instruction, registered.
- `ist_valid`  out  1  `ist` holds the instruction at `pc`.
- `commit`  out  1  one-cycle pulse; core gates PC write and register-file `rf_wen` with it.
- `lsu_req`  in  1  decode wants a data access; sampled only in EXEC.
- `lsu_wen`  in  1  1 = store, 0 = load.
- `lsu_addr`  in  ADDR_W  data address.
- `lsu_wdata`  in  32  store data.
- `lsu_wmask`  in  4  byte-enable mask for stores.
- `lsu_rdata`  out  32  registered load data.
- `halt_req`  in  1  decoded ebreak; sampled only in EXEC.
- `halted`  out  1  sticky halt flag.
- `err`  out  1  sticky bus-timeout flag.
- `mem_req`  out  1  memory request valid.
- `mem_addr`  out  ADDR_W  request address.
- `mem_wen`  out  1  request is a write.
- `mem_wdata`  out  32  write data.
- `mem_wmask`  out  4  write byte mask; 0 on reads.
- `mem_ready`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  response valid: read data, or write acknowledge.
- `mem_rdata`  in  32  read data.

## Operation
States: F_REQ, F_RSP, EXEC, D_REQ, D_RSP, COMMIT, HALT, ERR. Reset state is F_REQ.

- **F_REQ:** `mem_req`=1, `mem_addr`=`pc`, `mem_wen`=0.
  - `mem_ready`=1 → F_RSP.
- **F_RSP:** wait for `mem_rvalid`.
  - On `mem_rvalid`: `ist`←`mem_rdata`, `ist_valid`←1, → EXEC.
- **EXEC:** one cycle; decode is stable on `ist`. Priority order:
  1. `halt_req` → HALT.
  2. `lsu_req` → D_REQ; latch addr, wen, wdata and wmask into the request registers.
  3. Otherwise → COMMIT.
- **D_REQ:** `mem_req`=1 with the latched fields; `mem_wmask` is forced to 0 when `lsu_wen`=0.
  - `mem_ready` → D_RSP.
- **D_RSP:** wait for `mem_rvalid`.
  - On `mem_rvalid`: if load, `lsu_rdata`←`mem_rdata`. Go to COMMIT.
- **COMMIT:** `commit`=1 for exactly one cycle; `ist_valid`←0; → F_REQ. The core's PC updates on this edge.
- **HALT:** terminal until reset.
  - `halted`=1, no `commit`, `mem_req`=0.
  - `ist` and `ist_valid` hold their values.
- **ERR:** terminal until reset.
  - `err`=1, `mem_req`=0, no `commit`.

Handshake and timeout rules:
- While `mem_req`=1 and `mem_ready`=0, all `mem_*` outputs hold stable. A request is never withdrawn.
- `mem_rvalid` is ignored outside F_RSP and D_RSP.
- Wait counter: cleared on entry to F_REQ, F_RSP, D_REQ and D_RSP; increments each cycle spent in those states. If the counter reaches `TIMEOUT` before the exit condition → ERR.

## Timing
Reset values (asynchronous assert):
- State F_REQ.
- `ist`=0, `ist_valid`=0, `commit`=0, `lsu_rdata`=0.
- `halted`=0, `err`=0, wait counter 0.
- `mem_req` is 1 in the first cycle after `reset` goes high. While `reset` is low, `mem_req`=0.

Cycles per instruction with zero-wait memory (`mem_ready`=1 in the request cycle, `mem_rvalid` in the next cycle):
- Non-memory instruction: 4 cycles (F_REQ, F_RSP, EXEC, COMMIT).
- Load/store: 6 cycles.
- Each wait cycle adds one cycle.

Other timing rules:
- `ist` changes only on the F_RSP exit edge.
- `lsu_rdata` is valid from the cycle of COMMIT and holds until the next load response.
- `halt_req` and `lsu_req` asserted together in EXEC: halt wins, and no memory access is issued.
- Reset asserted mid-transaction: immediate return to reset values. Any response still in flight is the bus's responsibility; the bus shares the same `reset`.

## Structure
- Shared package `core_pkg`:
  - state encoding (3-bit, named constants for the 8 states);
  - `RESET_PC` = 0x8000_0000;
  - default `TIMEOUT`.
- One sub-module, `seq_timer`: a loadable wait counter with clear and expire outputs, width $clog2(TIMEOUT+1).
- The FSM, the instruction register and the data request/response registers all stay in `core_seq`.

## Test plan
- Zero-wait fetch of 0x00500093 (addi x1,x0,5) at `pc` 0x80000000:
  - `mem_req` in cycle 1 after reset release, `mem_addr`=0x80000000;
  - `ist`=0x00500093 in cycle 3;
  - `commit` pulse in cycle 4;
  - next `mem_req` in cycle 5.
- `mem_ready` held low for 3 cycles:
  - `mem_req`, `mem_addr` and `mem_wen` stay stable all 3 cycles;
  - F_RSP is entered on the cycle after `mem_ready`=1;
  - `commit` is 3 cycles later than in the zero-wait case.
- Load via `lsu_req`=1, `lsu_wen`=0, `lsu_addr`=0x80001000, `mem_rdata`=0xDEADBEEF:
  - data request has `mem_wmask`=0;
  - `lsu_rdata`=0xDEADBEEF during COMMIT;
  - 6-cycle instruction.
- Store with `lsu_wmask`=4'b0011, `lsu_wdata`=0x1234 → `mem_wen`=1, `mem_wmask`=0011, `mem_wdata`=0x1234; `commit` follows the acknowledge.
- `halt_req` and `lsu_req` both 1 in EXEC → `halted`=1 the next cycle, no data `mem_req`, no `commit` for 20 further cycles.
- `TIMEOUT`=8, `mem_rvalid` never asserted in F_RSP:
  - `err`=1 exactly after 8 cycles in F_RSP;
  - `mem_req`=0 afterward;
  - asserting `reset` low clears `err` asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 multi-cycle sequencer:
//   - seq_state_e : 3-bit encoding of the eight sequencer states
//   - RESET_PC    : address the core fetches first after reset
//   - DEFAULT_TIMEOUT : default bus wait limit in cycles
//   - is_wait_state / is_req_state : state classification helpers
// -----------------------------------------------------------------------------
package core_pkg;

    localparam logic [31:0] RESET_PC        = 32'h8000_0000;
    localparam int          DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        F_REQ  = 3'd0,
        F_RSP  = 3'd1,
        EXEC   = 3'd2,
        D_REQ  = 3'd3,
        D_RSP  = 3'd4,
        COMMIT = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } seq_state_e;

    // States that wait on the memory port and are guarded by the timeout
    function automatic logic is_wait_state(input seq_state_e st);
        logic wait_s;
        case (st)
            F_REQ, F_RSP, D_REQ, D_RSP: wait_s = 1'b1;
            default:                    wait_s = 1'b0;
        endcase
        return wait_s;
    endfunction

    // States that present a request on the memory port
    function automatic logic is_req_state(input seq_state_e st);
        logic req_s;
        case (st)
            F_REQ, D_REQ: req_s = 1'b1;
            default:      req_s = 1'b0;
        endcase
        return req_s;
    endfunction

endpackage

// File: rtl/core_seq_if.sv
// -----------------------------------------------------------------------------
// core_seq_if
// Single shared valid/ready memory port used for both instruction fetch and
// data access.
//   mem_req/mem_addr/mem_wen/mem_wdata/mem_wmask : request from the sequencer
//   mem_ready  : request accepted this cycle
//   mem_rvalid : read data valid or write acknowledge
//   mem_rdata  : read data
// Modports: master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface core_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/core_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Wait counter for the sequencer's bus states.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : reload the count with zero (takes priority over enable)
//   enable     : count one waited cycle
//   expire     : the current cycle is the TIMEOUT-th waited cycle
// The count saturates at TIMEOUT-1 so it never wraps back to a safe value.
// -----------------------------------------------------------------------------
module seq_timer
    import core_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter with clear-on-entry and saturation at the last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LAST);

endmodule

// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq
// Multi-cycle sequencer for the RV32 datapath. Fetches an instruction over the
// shared memory port, optionally performs one data access for the core, then
// pulses commit so the core writes its PC and register file.
//   clk, reset      : clock, asynchronous active-low reset
//   pc              : current PC from the core
//   ist, ist_valid  : held instruction and its valid flag
//   commit          : one-cycle PC / register-file write enable
//   lsu_*           : data access request from decode (sampled in EXEC)
//   lsu_rdata       : registered load data
//   halt_req        : decoded ebreak (sampled in EXEC)
//   halted, err     : sticky halt and bus-timeout flags
//   mem             : shared memory port (master side)
// -----------------------------------------------------------------------------
module core_seq
    import core_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ist,
    output logic              ist_valid,
    output logic              commit,
    input  logic              lsu_req,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic [DATA_W-1:0] lsu_rdata,
    input  logic              halt_req,
    output logic              halted,
    output logic              err,
    core_seq_if.master        mem
);

    seq_state_e        state_r;
    seq_state_e        next_state_s;

    logic              mem_req_r;
    logic              commit_r;
    logic              halted_r;
    logic              err_r;
    logic [DATA_W-1:0] ist_r;
    logic              ist_valid_r;
    logic [DATA_W-1:0] lsu_rdata_r;

    logic [ADDR_W-1:0] req_addr_r;
    logic              req_wen_r;
    logic [DATA_W-1:0] req_wdata_r;
    logic [3:0]        req_wmask_r;

    logic              req_accept_s;
    logic              rsp_seen_s;
    logic              counting_s;
    logic              timeout_s;
    logic              load_req_s;
    logic              timer_clear_s;
    logic              timer_expire_s;
    logic [ADDR_W-1:0] mem_addr_s;

    // Handshake qualifiers and timeout condition for the current cycle
    always_comb begin
        req_accept_s = mem_req_r & mem.mem_ready;
        rsp_seen_s   = ((state_r == F_RSP) || (state_r == D_RSP)) & mem.mem_rvalid;
        // The first cycle out of reset sits in F_REQ with mem_req still low;
        // nothing is outstanding yet, so it does not count as waiting.
        counting_s   = is_wait_state(state_r) & ~((state_r == F_REQ) & ~mem_req_r);
        timeout_s    = counting_s & timer_expire_s;
        load_req_s   = (state_r == EXEC) & ~halt_req & lsu_req;
    end

    // Next-state decode; a handshake in the expiring cycle still wins over ERR
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            F_REQ: begin
                if (req_accept_s)   next_state_s = F_RSP;
                else if (timeout_s) next_state_s = ERR;
                else                next_state_s = F_REQ;
            end
            F_RSP: begin
                if (rsp_seen_s)     next_state_s = EXEC;
                else if (timeout_s) next_state_s = ERR;
                else                next_state_s = F_RSP;
            end
            EXEC: begin
                if (halt_req)       next_state_s = HALT;
                else if (lsu_req)   next_state_s = D_REQ;
                else                next_state_s = COMMIT;
            end
            D_REQ: begin
                if (req_accept_s)   next_state_s = D_RSP;
                else if (timeout_s) next_state_s = ERR;
                else                next_state_s = D_REQ;
            end
            D_RSP: begin
                if (rsp_seen_s)     next_state_s = COMMIT;
                else if (timeout_s) next_state_s = ERR;
                else                next_state_s = D_RSP;
            end
            COMMIT:  next_state_s = F_REQ;
            HALT:    next_state_s = HALT;
            ERR:     next_state_s = ERR;
            default: next_state_s = ERR;
        endcase
    end

    // Any state change restarts the wait count for the state being entered
    always_comb begin
        timer_clear_s = (next_state_s != state_r);
    end

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .enable (counting_s),
        .expire (timer_expire_s)
    );

    // State register plus per-state flags decoded from the next state so they leave flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= F_REQ;
            mem_req_r <= 1'b0;
            commit_r  <= 1'b0;
            halted_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            mem_req_r <= is_req_state(next_state_s);
            commit_r  <= (next_state_s == COMMIT);
            halted_r  <= (next_state_s == HALT);
            err_r     <= (next_state_s == ERR);
        end
    end

    // Instruction register: loaded only by the fetch response, invalidated on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ist_r       <= {DATA_W{1'b0}};
            ist_valid_r <= 1'b0;
        end else if ((state_r == F_RSP) && rsp_seen_s) begin
            ist_r       <= mem.mem_rdata;
            ist_valid_r <= 1'b1;
        end else if (state_r == COMMIT) begin
            ist_r       <= ist_r;
            ist_valid_r <= 1'b0;
        end else begin
            ist_r       <= ist_r;
            ist_valid_r <= ist_valid_r;
        end
    end

    // Data request registers: captured in EXEC, write qualifiers dropped once the data phase ends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_r  <= {ADDR_W{1'b0}};
            req_wen_r   <= 1'b0;
            req_wdata_r <= {DATA_W{1'b0}};
            req_wmask_r <= 4'b0000;
        end else if (load_req_s) begin
            req_addr_r  <= lsu_addr;
            req_wen_r   <= lsu_wen;
            req_wdata_r <= lsu_wdata;
            // Reads never carry byte enables
            req_wmask_r <= lsu_wen ? lsu_wmask : 4'b0000;
        end else if ((next_state_s != D_REQ) && (next_state_s != D_RSP)) begin
            req_addr_r  <= req_addr_r;
            req_wen_r   <= 1'b0;
            req_wdata_r <= req_wdata_r;
            req_wmask_r <= 4'b0000;
        end else begin
            req_addr_r  <= req_addr_r;
            req_wen_r   <= req_wen_r;
            req_wdata_r <= req_wdata_r;
            req_wmask_r <= req_wmask_r;
        end
    end

    // Load data register: updated only by a read response in the data phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lsu_rdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == D_RSP) && rsp_seen_s && !req_wen_r) begin
            lsu_rdata_r <= mem.mem_rdata;
        end else begin
            lsu_rdata_r <= lsu_rdata_r;
        end
    end

    // Fetch address follows the core PC (stable until commit); the data phase uses the latched address
    always_comb begin
        mem_addr_s = pc;
        if (state_r == D_REQ) begin
            mem_addr_s = req_addr_r;
        end else begin
            mem_addr_s = pc;
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_addr  = mem_addr_s;
    assign mem.mem_wen   = req_wen_r;
    assign mem.mem_wdata = req_wdata_r;
    assign mem.mem_wmask = req_wmask_r;

    assign ist       = ist_r;
    assign ist_valid = ist_valid_r;
    assign commit    = commit_r;
    assign lsu_rdata = lsu_rdata_r;
    assign halted    = halted_r;
    assign err       = err_r;

endmodule

// File: tb/tb_core_seq.sv
// -----------------------------------------------------------------------------
// tb_core_seq
// Directed bench for core_seq with TIMEOUT=8. The bench plays both the core
// (pc, lsu_*, halt_req) and the memory (mem_ready, mem_rvalid, mem_rdata).
// Inputs change and outputs are sampled on the falling edge. Cycle k means the
// interval after the k-th rising edge following reset release.
// -----------------------------------------------------------------------------
module tb_core_seq;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ist;
    logic              ist_valid;
    logic              commit;
    logic              lsu_req;
    logic              lsu_wen;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [3:0]        lsu_wmask;
    logic [DATA_W-1:0] lsu_rdata;
    logic              halt_req;
    logic              halted;
    logic              err;

    logic saw_commit;
    logic saw_req;

    int n_cmp = 0;
    int n_err = 0;

    core_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    core_seq #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .ist       (ist),
        .ist_valid (ist_valid),
        .commit    (commit),
        .lsu_req   (lsu_req),
        .lsu_wen   (lsu_wen),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_wmask (lsu_wmask),
        .lsu_rdata (lsu_rdata),
        .halt_req  (halt_req),
        .halted    (halted),
        .err       (err),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        pc        = core_pkg::RESET_PC;
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        lsu_addr  = 32'h0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'b0000;
        halt_req  = 1'b0;
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = 32'h0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_mem_req",   mem_bus.mem_req, 32'd0);
        check("rst_ist",       ist,             32'd0);
        check("rst_ist_valid", ist_valid,       32'd0);
        check("rst_commit",    commit,          32'd0);
        check("rst_lsu_rdata", lsu_rdata,       32'd0);
        check("rst_halted",    halted,          32'd0);
        check("rst_err",       err,             32'd0);

        // ---------------- zero-wait fetch of addi x1,x0,5 ----------------
        mem_bus.mem_ready = 1'b1;
        reset = 1'b1;
        tick();                                              // cycle 1: F_REQ
        check("zw_c1_mem_req",  mem_bus.mem_req,  32'd1);
        check("zw_c1_mem_addr", mem_bus.mem_addr, 32'h8000_0000);
        check("zw_c1_mem_wen",  mem_bus.mem_wen,  32'd0);
        tick();                                              // cycle 2: F_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0050_0093;
        check("zw_c2_mem_req",   mem_bus.mem_req, 32'd0);
        check("zw_c2_ist_valid", ist_valid,       32'd0);
        tick();                                              // cycle 3: EXEC
        mem_bus.mem_rvalid = 1'b0;
        check("zw_c3_ist",       ist,       32'h0050_0093);
        check("zw_c3_ist_valid", ist_valid, 32'd1);
        check("zw_c3_commit",    commit,    32'd0);
        tick();                                              // cycle 4: COMMIT
        check("zw_c4_commit",  commit,          32'd1);
        check("zw_c4_mem_req", mem_bus.mem_req, 32'd0);
        pc = 32'h8000_0004;
        tick();                                              // cycle 5: F_REQ
        check("zw_c5_mem_req",   mem_bus.mem_req,  32'd1);
        check("zw_c5_mem_addr",  mem_bus.mem_addr, 32'h8000_0004);
        check("zw_c5_commit",    commit,           32'd0);
        check("zw_c5_ist_valid", ist_valid,        32'd0);

        // ---------------- mem_ready low for 3 cycles (cycles 5..7) ----------------
        for (int i = 0; i < 3; i++) begin
            check("st_mem_req",  mem_bus.mem_req,  32'd1);
            check("st_mem_addr", mem_bus.mem_addr, 32'h8000_0004);
            check("st_mem_wen",  mem_bus.mem_wen,  32'd0);
            tick();
        end
        mem_bus.mem_ready = 1'b1;                            // cycle 8: accepted
        check("st_c8_mem_req", mem_bus.mem_req, 32'd1);
        tick();                                              // cycle 9: F_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0010_0113;
        check("st_c9_in_f_rsp", mem_bus.mem_req, 32'd0);
        tick();                                              // cycle 10: EXEC
        mem_bus.mem_rvalid = 1'b0;
        check("st_c10_ist",    ist,    32'h0010_0113);
        check("st_c10_commit", commit, 32'd0);
        tick();                                              // cycle 11: COMMIT
        check("st_c11_commit", commit, 32'd1);
        pc = 32'h8000_0008;
        mem_bus.mem_ready = 1'b1;

        // ---------------- load (cycles 12..17) ----------------
        tick();                                              // 12: F_REQ
        check("ld_f_mem_addr", mem_bus.mem_addr, 32'h8000_0008);
        tick();                                              // 13: F_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0000_A083;
        tick();                                              // 14: EXEC
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_ready  = 1'b1;
        lsu_req   = 1'b1;
        lsu_wen   = 1'b0;
        lsu_addr  = 32'h8000_1000;
        lsu_wdata = 32'hFFFF_FFFF;
        lsu_wmask = 4'b1111;
        check("ld_exec_ist", ist, 32'h0000_A083);
        tick();                                              // 15: D_REQ
        lsu_req  = 1'b0;
        lsu_addr = 32'h0;
        check("ld_d_mem_req",   mem_bus.mem_req,   32'd1);
        check("ld_d_mem_addr",  mem_bus.mem_addr,  32'h8000_1000);
        check("ld_d_mem_wen",   mem_bus.mem_wen,   32'd0);
        check("ld_d_mem_wmask", mem_bus.mem_wmask, 32'd0);
        tick();                                              // 16: D_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hDEAD_BEEF;
        check("ld_rsp_mem_req", mem_bus.mem_req, 32'd0);
        check("ld_rsp_commit",  commit,          32'd0);
        tick();                                              // 17: COMMIT
        mem_bus.mem_rvalid = 1'b0;
        check("ld_commit",       commit,    32'd1);
        check("ld_commit_rdata", lsu_rdata, 32'hDEAD_BEEF);
        pc = 32'h8000_000C;
        mem_bus.mem_ready = 1'b1;
        tick();                                              // 18: F_REQ
        check("ld_next_mem_req", mem_bus.mem_req, 32'd1);
        check("ld_next_commit",  commit,          32'd0);
        check("ld_rdata_hold",   lsu_rdata,       32'hDEAD_BEEF);

        // ---------------- store with one-cycle acknowledge wait (cycles 18..24) ----------------
        check("sw_f_mem_addr", mem_bus.mem_addr, 32'h8000_000C);
        tick();                                              // 19: F_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0011_2023;
        tick();                                              // 20: EXEC
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_ready  = 1'b1;
        lsu_req   = 1'b1;
        lsu_wen   = 1'b1;
        lsu_addr  = 32'h8000_1004;
        lsu_wdata = 32'h0000_1234;
        lsu_wmask = 4'b0011;
        tick();                                              // 21: D_REQ
        lsu_req   = 1'b0;
        lsu_wen   = 1'b0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'b0000;
        check("sw_d_mem_req",   mem_bus.mem_req,   32'd1);
        check("sw_d_mem_addr",  mem_bus.mem_addr,  32'h8000_1004);
        check("sw_d_mem_wen",   mem_bus.mem_wen,   32'd1);
        check("sw_d_mem_wmask", mem_bus.mem_wmask, 32'h3);
        check("sw_d_mem_wdata", mem_bus.mem_wdata, 32'h0000_1234);
        tick();                                              // 22: D_RSP, no ack yet
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
        check("sw_wait_commit", commit, 32'd0);
        tick();                                              // 23: D_RSP, ack
        mem_bus.mem_rvalid = 1'b1;
        check("sw_ack_commit", commit, 32'd0);
        tick();                                              // 24: COMMIT
        mem_bus.mem_rvalid = 1'b0;
        check("sw_commit",      commit,    32'd1);
        check("sw_rdata_keeps", lsu_rdata, 32'hDEAD_BEEF);
        pc = 32'h8000_0010;
        mem_bus.mem_ready = 1'b1;

        // ---------------- halt and lsu together (cycles 25..) ----------------
        tick();                                              // 25: F_REQ
        check("hl_f_mem_addr", mem_bus.mem_addr, 32'h8000_0010);
        tick();                                              // 26: F_RSP
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h0010_0073;
        tick();                                              // 27: EXEC
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_ready  = 1'b1;
        halt_req = 1'b1;
        lsu_req  = 1'b1;
        lsu_wen  = 1'b1;
        lsu_addr = 32'h8000_2000;
        check("hl_exec_halted", halted, 32'd0);
        tick();                                              // 28: HALT
        halt_req = 1'b0;
        lsu_req  = 1'b0;
        lsu_wen  = 1'b0;
        check("hl_halted",    halted,          32'd1);
        check("hl_mem_req",   mem_bus.mem_req, 32'd0);
        check("hl_ist",       ist,             32'h0010_0073);
        check("hl_ist_valid", ist_valid,       32'd1);
        mem_bus.mem_rvalid = 1'b1;
        saw_commit = 1'b0;
        saw_req    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            saw_commit = saw_commit | commit;
            saw_req    = saw_req | mem_bus.mem_req;
            tick();
        end
        mem_bus.mem_rvalid = 1'b0;
        check("hl_no_commit_20", saw_commit, 32'd0);
        check("hl_no_req_20",    saw_req,    32'd0);
        check("hl_still_halted", halted,     32'd1);

        // ---------------- asynchronous reset from HALT ----------------
        #2;
        reset = 1'b0;
        #1;
        check("ar_halted",    halted,          32'd0);
        check("ar_ist",       ist,             32'd0);
        check("ar_ist_valid", ist_valid,       32'd0);
        check("ar_mem_req",   mem_bus.mem_req, 32'd0);
        @(negedge clk);
        check("ar_hold_mem_req", mem_bus.mem_req, 32'd0);

        // ---------------- fetch timeout, TIMEOUT=8 ----------------
        pc = core_pkg::RESET_PC;
        mem_bus.mem_ready = 1'b1;
        reset = 1'b1;
        tick();                                              // cycle 1: F_REQ
        check("to_c1_mem_req",  mem_bus.mem_req,  32'd1);
        check("to_c1_mem_addr", mem_bus.mem_addr, 32'h8000_0000);
        tick();                                              // cycle 2: first F_RSP cycle
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin                    // cycles 2..9 in F_RSP
            check("to_wait_err", err, 32'd0);
            tick();
        end
        check("to_err",     err,             32'd1);         // cycle 10
        check("to_mem_req", mem_bus.mem_req, 32'd0);
        mem_bus.mem_ready  = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        repeat (3) tick();
        check("to_err_sticky",  err,             32'd1);
        check("to_req_stays_0", mem_bus.mem_req, 32'd0);
        check("to_no_commit",   commit,          32'd0);
        mem_bus.mem_rvalid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("to_reset_clears_err", err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
